// File: rtl/fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ctrl_pkg
//  Purpose  : Shared types and constants for the FIFO drain controller.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_ctrl_pkg;

    // Skid holds one in-flight word plus one arriving during a stall
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PAUSED = 2'd2
    } state_t;

endpackage : fifo_ctrl_pkg
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
//  Module   : skid_buf2
//  Purpose  : Two-entry register FIFO with combinational head output.
//  Revision : 1.0  initial release
// ============================================================================
module skid_buf2
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr,
    input  logic [DATA_SIZE-1:0] wr_data,
    input  logic                 rd,
    output logic [DATA_SIZE-1:0] head,
    output logic [1:0]           count
);

    logic [DATA_SIZE-1:0] r_mem [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;
    logic                 w_rd_ok;
    logic                 w_wr_ok;

    // A read needs a stored word; a write into a full buffer is only legal
    // when the head leaves in the same cycle.
    assign w_rd_ok = rd && (r_count != 2'd0);
    assign w_wr_ok = wr && ((r_count != 2'(SKID_DEPTH)) || w_rd_ok);

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_wr_ok) begin
                r_mem[r_wr_ptr] <= wr_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : skid_buf2
`default_nettype wire

// File: rtl/fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_drain_ctrl
//  Purpose  : Pops a source FIFO, absorbs the one-cycle pop latency and pushes
//             words in order into a destination FIFO, riding out pause/full
//             with a two-entry skid buffer.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_drain_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_SIZE = 10,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 src_empty,
    input  logic [DATA_SIZE-1:0] src_data,
    output logic                 src_pop,
    input  logic                 dst_pause,
    input  logic                 dst_full,
    output logic                 dst_push,
    output logic [DATA_SIZE-1:0] dst_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     fwd_count,
    output logic                 overflow_err
);

    state_t               r_state;
    logic                 r_inflight;
    logic [CNT_W-1:0]     r_fwd_count;
    logic                 r_overflow;

    logic [1:0]           w_skid_count;
    logic [DATA_SIZE-1:0] w_skid_head;
    logic [1:0]           w_occ;
    logic                 w_skid_has;
    logic                 w_avail;
    logic                 w_skid_wr;
    logic                 w_skid_rd;

    // Words owed downstream: stored in the skid plus the one arriving now
    assign w_occ      = w_skid_count + {1'b0, r_inflight};
    assign w_skid_has = (w_skid_count != 2'd0);
    assign w_avail    = w_skid_has || r_inflight;

    // Only pop when there is guaranteed room for the word in the skid
    assign src_pop  = (r_state == ACTIVE) && !src_empty && !dst_pause
                      && (w_occ < 2'(SKID_DEPTH));

    // Oldest skid entry goes first; otherwise the arriving word bypasses
    assign dst_push = w_avail && !dst_full;
    assign dst_data = dst_push ? (w_skid_has ? w_skid_head : src_data) : '0;

    // Arriving word is stored unless it was the one pushed this cycle
    assign w_skid_rd = dst_push && w_skid_has;
    assign w_skid_wr = r_inflight && (w_skid_has || dst_full);

    assign busy         = (r_state != IDLE);
    assign fwd_count    = r_fwd_count;
    assign overflow_err = r_overflow;

    skid_buf2 #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .wr      (w_skid_wr),
        .wr_data (src_data),
        .rd      (w_skid_rd),
        .head    (w_skid_head),
        .count   (w_skid_count)
    );

    // Pop latency tracking, forwarded-word counter and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inflight  <= 1'b0;
            r_fwd_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_inflight  <= src_pop;
            r_fwd_count <= r_fwd_count + CNT_W'(dst_push);
            if (r_inflight && (w_skid_count == 2'(SKID_DEPTH)) && !dst_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Control FSM: pause takes priority over going idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!src_empty) r_state <= ACTIVE;
                end
                ACTIVE: begin
                    if (dst_pause)                         r_state <= PAUSED;
                    else if (src_empty && (w_occ == 2'd0)) r_state <= IDLE;
                end
                PAUSED: begin
                    if (!dst_pause) r_state <= ACTIVE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : fifo_drain_ctrl
`default_nettype wire

// File: tb/tb_fifo_drain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_drain_ctrl
//  Purpose  : Self-checking bench for fifo_drain_ctrl against a word-level
//             source/destination model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_drain_ctrl;

    localparam int DW = 10;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          src_empty;
    logic [DW-1:0] src_data;
    logic          src_pop;
    logic          dst_pause;
    logic          dst_full;
    logic          dst_push;
    logic [DW-1:0] dst_data;
    logic          busy;
    logic [CW-1:0] fwd_count;
    logic          overflow_err;

    fifo_drain_ctrl #(.DATA_SIZE(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .src_empty    (src_empty),
        .src_data     (src_data),
        .src_pop      (src_pop),
        .dst_pause    (dst_pause),
        .dst_full     (dst_full),
        .dst_push     (dst_push),
        .dst_data     (dst_data),
        .busy         (busy),
        .fwd_count    (fwd_count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Source FIFO contents and expected destination order
    logic [DW-1:0] src_q [$];
    logic [DW-1:0] exp_q [$];
    int unsigned   pops, pushes;
    int            cyc, first_pop_cyc, first_push_cyc, last_push_cyc;
    int            busy_falls;
    bit            pop_prev, busy_prev, mon_en;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Word-level rules seen at the ports each cycle
    task automatic monitor();
        int held;
        held = int'(pops - pushes);
        check_val("pop_while_empty", 32'(src_pop & src_empty), 0);
        check_val("pop_while_pause", 32'(src_pop & dst_pause), 0);
        check_val("pop_when_skid_full", 32'(src_pop && held >= 2), 0);
        check_val("held_le_2", 32'(held <= 2), 1);
        check_val("dst_push", 32'(dst_push), 32'(held > 0 && !dst_full));
        check_val("fwd_count", 32'(fwd_count), 32'(pushes % 65536));
        check_val("overflow_err", 32'(overflow_err), 0);
        if (dst_push) begin
            if (exp_q.size() == 0) check_val("push_without_word", 1, 0);
            else                   check_val("dst_data", 32'(dst_data), 32'(exp_q.pop_front()));
            pushes++;
            if (first_push_cyc < 0) first_push_cyc = cyc;
            last_push_cyc = cyc;
        end
        if (src_pop) begin
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
        end
        if (busy_prev && !busy) busy_falls++;
        busy_prev = busy;
    endtask

    // One clock: source pops land after the edge, knobs applied, then sample
    task automatic tick(input bit pause, input bit full, input bit force_empty);
        @(posedge clk);
        #1;
        if (pop_prev && src_q.size() > 0) src_data = src_q.pop_front();
        dst_pause = pause;
        dst_full  = full;
        src_empty = force_empty || (src_q.size() == 0);
        @(negedge clk);
        cyc++;
        if (mon_en) monitor();
        pop_prev = src_pop && !reset;
    endtask

    task automatic load(input int n, input bit rnd, input int base);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? DW'($urandom) : DW'(base + i);
            src_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_pop"},   32'(src_pop), 0);
        check_val({tag, "_push"},  32'(dst_push), 0);
        check_val({tag, "_data"},  32'(dst_data), 0);
        check_val({tag, "_busy"},  32'(busy), 0);
        check_val({tag, "_count"}, 32'(fwd_count), 0);
        check_val({tag, "_ovf"},   32'(overflow_err), 0);
    endtask

    // Reset for three cycles from wherever the stream is
    task automatic do_reset();
        reset  = 1'b1;
        mon_en = 1'b0;
        #1;
        check_zero_outputs("rst_async");
        src_q.delete();
        exp_q.delete();
        pops = 0; pushes = 0;
        first_pop_cyc = -1; first_push_cyc = -1; last_push_cyc = -1;
        busy_falls = 0; busy_prev = 1'b0; pop_prev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            check_zero_outputs("rst_hold");
        end
        reset  = 1'b0;
        mon_en = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        check_val("post_rst_pop", 32'(src_pop), 0);
        check_val("post_rst_busy", 32'(busy), 0);
    endtask

    // mode 0: clean; 1: random src_empty; 2: random everything
    task automatic drain(input string tag, input int budget, input int mode);
        int n = 0;
        bit p, f, e;
        while ((exp_q.size() > 0) && (n < budget)) begin
            p = (mode == 2) && ($urandom_range(0, 3) == 0);
            f = (mode == 2) && ($urandom_range(0, 9) < 3);
            e = (mode != 0) && ($urandom_range(0, 9) < ((mode == 1) ? 5 : 2));
            tick(p, f, e);
            n++;
        end
        check_val({tag, "_drained"}, 32'(exp_q.size()), 0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        check_val({tag, "_idle_busy"}, 32'(busy), 0);
        check_val({tag, "_count_end"}, 32'(fwd_count), 32'(pushes % 65536));
    endtask

    initial begin
        int t0, hold_pops;
        reset = 1'b0; src_empty = 1'b1; src_data = '0;
        dst_pause = 1'b0; dst_full = 1'b0;
        cyc = 0; pops = 0; pushes = 0; mon_en = 1'b0;
        pop_prev = 1'b0; busy_prev = 1'b0; busy_falls = 0;
        first_pop_cyc = -1; first_push_cyc = -1; last_push_cyc = -1;

        // Power-on reset, then reset in the middle of a stream
        do_reset();
        load(20, 1'b1, 0);
        for (int i = 0; i < 6; i++) tick(1'b0, (i > 3), 1'b0);
        do_reset();

        // Streaming 0x001..0x008 with no stalls
        load(8, 1'b0, 1);
        drain("stream", 40, 0);
        check_val("stream_count", 32'(fwd_count), 8);
        check_val("stream_latency", 32'(first_push_cyc - first_pop_cyc), 1);
        check_val("stream_back_to_back", 32'(last_push_cyc - first_push_cyc), 7);
        check_val("stream_fell", 32'(busy_falls), 1);

        // Pause raised once the third word has been popped
        load(8, 1'b0, 1);
        t0 = 0;
        while (pops < 8 + 3 && t0 < 40) begin tick(1'b0, 1'b0, 1'b0); t0++; end
        hold_pops = int'(pops);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0);
        check_val("pause_no_pop", pops, hold_pops);
        check_val("pause_drained", pushes, pops);
        check_val("pause_busy", 32'(busy), 1);
        drain("pause", 40, 0);

        // Destination full for five cycles mid-stream
        load(10, 1'b1, 0);
        t0 = 0;
        while (pops < 16 + 2 && t0 < 40) begin tick(1'b0, 1'b0, 1'b0); t0++; end
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0);
        check_val("full_held", pops - pushes, 2);
        drain("full", 40, 0);

        // src_empty flickering
        busy_falls = 0;
        load(8, 1'b1, 0);
        drain("empty", 400, 1);
        check_val("empty_bounce", 32'(busy_falls > 1), 1);

        // Fully random pause/full/empty
        load(200, 1'b1, 0);
        drain("random", 3000, 2);

        // Forwarded-word counter wrap
        do_reset();
        load(65537, 1'b0, 0);
        drain("wrap", 66000, 0);
        check_val("wrap_count", 32'(fwd_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_drain_ctrl
`default_nettype wire
